button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Multi-channel, parametrised successor to the single-button debounce + one-pulse pair.
//   Each channel synchronises a raw pushbutton and debounces it with a counter.
//   Each channel outputs a clean level plus one-cycle press and release strobes.
//   Optional auto-repeat strobes. Sits between board buttons and control FSMs (e.g. UART send).
// PARAMETERS
//   CHANNELS             5           number of independent button channels (>=1)
//   DEBOUNCE_CYCLES      1_000_000   consecutive stable clocks needed to accept a new level (>=1)
//   ACTIVE_HIGH          1           1: pressed = 1 on btn_in; 0: inputs inverted before sync
//   REPEAT_DELAY_CYCLES  50_000_000  hold time from press to first repeat strobe (>=1)
//   REPEAT_RATE_CYCLES   10_000_000  period between subsequent repeat strobes (>=1)
// PORTS
//   clk          in   1         system clock
//   rst          in   1         asynchronous, active-low reset
//   btn_in       in   CHANNELS  raw asynchronous button inputs
//   btn_level    out  CHANNELS  debounced level, 1 = pressed
//   btn_press    out  CHANNELS  1-cycle strobe on accepted 0->1 of btn_level
//   btn_release  out  CHANNELS  1-cycle strobe on accepted 1->0 of btn_level
//   btn_repeat   out  CHANNELS  1-cycle auto-repeat strobe while held (0 when feature off)
// BEHAVIOUR
//   - Reset (rst=0, async): sync flops, counters, btn_level, all strobes -> 0. Deassertion is sampled on clk.
//   - Per channel, polarity-adjusted input passes a 2-flop synchroniser -> s.
//   - Debounce counter dcnt: if s == btn_level, dcnt <= 0.
//     Else if dcnt == DEBOUNCE_CYCLES-1: btn_level <= s and dcnt <= 0. Else dcnt <= dcnt+1.
//   - Latency: a stable input change is reflected on btn_level exactly DEBOUNCE_CYCLES+2 clocks later.
//     Any glitch shorter than DEBOUNCE_CYCLES clocks at s produces no output change.
//   - btn_press / btn_release are registered. Each is high for exactly the first cycle in which btn_level shows the new value.
//     Never both high on the same channel in the same cycle.
//   - Channels are fully independent. Simultaneous events on several channels yield simultaneous strobes.
//   - Counter width = $clog2(max cycle param + 1). No counter ever wraps: each saturates/clears as above.
//   - Mid-operation reset discards any partial count. After reset, a held button is treated as a new press,
//     with press after DEBOUNCE_CYCLES+2 clocks.
// CONFIGURATION
//   Macro BTN_AUTO_REPEAT_EN.
//   - Defined: a per-channel repeat counter rcnt runs while btn_level=1. It is cleared on btn_press and whenever btn_level=0.
//     btn_repeat pulses for 1 cycle when REPEAT_DELAY_CYCLES have elapsed since the btn_press cycle.
//     It then pulses every REPEAT_RATE_CYCLES until release. btn_press itself never coincides with btn_repeat.
//   - Undefined: no repeat counters are synthesised. btn_repeat is tied to 0 and the port list is unchanged.
// STRUCTURE
//   - Package button_pkg: function cnt_width(int n) returning $clog2(n+1).
//     The package also holds default constants for the debounce and repeat cycle counts at 100 MHz.
//   - Sub-module btn_channel: one channel (synchroniser, debounce FSM, strobes, optional repeat).
//     The top instantiates it CHANNELS times in a generate loop.
//   - Per-channel debounce state: IDLE_LOW, COUNT_UP, HELD_HIGH, COUNT_DOWN.
//     It is encoded implicitly by (btn_level, dcnt!=0).
// TESTING (sim with DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3, CHANNELS=3)
//   1. Clean press on ch0 at cycle 0, held. Expected: btn_level[0]=1 and btn_press[0]=1 at cycle 6 only.
//      btn_press[0]=0 at cycle 7. Other channels stay 0.
//   2. Bounce on ch1: pulses 3 cycles high / 2 low repeated, then stable high.
//      Expected: no strobe during the bounce. Exactly one btn_press[1], 6 cycles after the final stable edge.
//   3. Release after scenario 1. Expected: btn_release[0] pulses once 6 cycles after btn_in[0] falls.
//      btn_level[0] falls in that same cycle.
//   4. ch0 and ch2 pressed in the same cycle. Expected: btn_press[0] and btn_press[2] strobe in the same cycle.
//   5. Assert rst mid-count (dcnt=2) on a rising input. Expected: outputs 0 immediately (async).
//      After release of rst with input still high, press arrives 6 cycles later.
//   6. With BTN_AUTO_REPEAT_EN, hold ch0. Expected: btn_repeat[0] at press+10, +13, +16.
//      No further repeat after release. Without the macro, btn_repeat stays 0 throughout.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants, debounce state encoding and counter-sizing helpers
// for the button_conditioner block.
package button_pkg;

    // Defaults assume a 100 MHz clk: 10 ms debounce, 500 ms repeat delay, 100 ms repeat rate.
    localparam int DEFAULT_DEBOUNCE_CYCLES     = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY_CYCLES = 50_000_000;
    localparam int DEFAULT_REPEAT_RATE_CYCLES  = 10_000_000;

    typedef enum logic [1:0] {
        IDLE_LOW,
        COUNT_UP,
        HELD_HIGH,
        COUNT_DOWN
    } deb_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release strobes.
// Auto-repeat strobe only when BTN_AUTO_REPEAT_EN is defined, otherwise repeat_o is 0.
//
// state      | meaning
// IDLE_LOW   | level 0, input agrees (dcnt == 0)
// COUNT_UP   | level 0, input high, counting toward acceptance
// HELD_HIGH  | level 1, input agrees (dcnt == 0)
// COUNT_DOWN | level 1, input low, counting toward acceptance
module btn_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_HIGH         = 1,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CW = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          raw;
    logic          sync1_q, s_q;
    logic          level_q, level_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    deb_state_t    state;

    assign raw = (ACTIVE_HIGH != 0) ? btn_i : ~btn_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= raw;
            s_q     <= sync1_q;
        end
    end

    // State is not stored separately; it is recovered from the level and the counter.
    always_comb begin
        if (level_q) state = (dcnt_q != '0) ? COUNT_DOWN : HELD_HIGH;
        else         state = (dcnt_q != '0) ? COUNT_UP   : IDLE_LOW;
    end

    always_comb begin
        level_d   = level_q;
        dcnt_d    = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state)
            IDLE_LOW, COUNT_UP: begin
                if (s_q) begin
                    if (dcnt_q == DEB_LAST) begin
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
            end
            HELD_HIGH, COUNT_DOWN: begin
                if (!s_q) begin
                    if (dcnt_q == DEB_LAST) begin
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q   <= 1'b0;
            dcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE_CYCLES - 1);

    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rfirst_q, rfirst_d;
    logic          repeat_q, repeat_d;

    // rcnt is 0 in the press cycle; requiring level_d keeps a repeat off the release cycle.
    always_comb begin
        rcnt_d   = '0;
        rfirst_d = 1'b1;
        repeat_d = 1'b0;
        if (level_q && level_d) begin
            rfirst_d = rfirst_q;
            if (rcnt_q == (rfirst_q ? RD_LAST : RR_LAST)) begin
                repeat_d = 1'b1;
                rfirst_d = 1'b0;
            end else begin
                rcnt_d = rcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: CHANNELS independent btn_channel instances.
// Auto-repeat strobes are built only when BTN_AUTO_REPEAT_EN is defined.
module button_conditioner
    import button_pkg::*;
#(
    parameter int CHANNELS            = 5,
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_HIGH         = 1,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .ACTIVE_HIGH        (ACTIVE_HIGH),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
        ) u_channel (
            .clk_i    (clk),
            .rst_ni   (rst),
            .btn_i    (btn_in[ch]),
            .level_o  (btn_level[ch]),
            .press_o  (btn_press[ch]),
            .release_o(btn_release[ch]),
            .repeat_o (btn_repeat[ch])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random toggling, checked by
// a window-based reference model feeding a strobe scoreboard.
module tb_button_conditioner;

    localparam int CH   = 3;
    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RR   = 3;
    localparam int MAXC = 8192;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .ACTIVE_HIGH(1),
        .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_n;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic [CH-1:0] rp;
    } ev_t;

    ev_t           sbq[$];
    bit            hist[CH][MAXC];
    int            cur_edge = -1;
    logic [CH-1:0] m_level = '0;
    int            press_edge[CH];

    // Reference: level flips once the last D synchronised samples (2 edges old) all disagree with it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_edge = -1;
            m_level  = '0;
            sbq.delete();
        end else begin
            ev_t           ev;
            logic [CH-1:0] nl;
            cur_edge++;
            if (cur_edge >= MAXC) begin
                $display("FAIL model_capacity edge=%0d limit=%0d", cur_edge, MAXC);
                $fatal(1);
            end
            ev.edge_n = cur_edge;
            ev.pr = '0; ev.rl = '0; ev.rp = '0;
            nl = m_level;
            for (int c = 0; c < CH; c++) begin
                bit all_diff;
                hist[c][cur_edge] = btn_in[c];
                all_diff = 1'b1;
                for (int j = cur_edge - 1 - D; j <= cur_edge - 2; j++) begin
                    bit v;
                    v = (j < 0) ? 1'b0 : hist[c][j];
                    if (v == m_level[c]) all_diff = 1'b0;
                end
                if (all_diff) nl[c] = ~m_level[c];
                if (nl[c] && !m_level[c]) begin
                    ev.pr[c] = 1'b1;
                    press_edge[c] = cur_edge;
                end
                if (!nl[c] && m_level[c]) ev.rl[c] = 1'b1;
                if (REP_ON && nl[c] && m_level[c]) begin
                    int d;
                    d = cur_edge - press_edge[c];
                    if (d >= RD && ((d - RD) % RR) == 0) ev.rp[c] = 1'b1;
                end
            end
            m_level = nl;
            if ((ev.pr | ev.rl | ev.rp) != '0) sbq.push_back(ev);
        end
    end

    always @(negedge clk) begin
        if (rst && cur_edge >= 0) begin
            checks++;
            if (btn_level !== m_level) begin
                errors++;
                $display("FAIL level edge=%0d got=%b exp=%b", cur_edge, btn_level, m_level);
            end
            while (sbq.size() > 0 && sbq[0].edge_n < cur_edge) begin
                ev_t lost;
                lost = sbq.pop_front();
                checks++; errors++;
                $display("FAIL missed_strobe edge=%0d got=none exp press=%b release=%b repeat=%b",
                         lost.edge_n, lost.pr, lost.rl, lost.rp);
            end
            if (sbq.size() > 0 && sbq[0].edge_n == cur_edge) begin
                ev_t e;
                e = sbq.pop_front();
                checks++;
                if (btn_press !== e.pr || btn_release !== e.rl || btn_repeat !== e.rp) begin
                    errors++;
                    $display("FAIL strobes edge=%0d got p/r/rp=%b/%b/%b exp=%b/%b/%b",
                             cur_edge, btn_press, btn_release, btn_repeat, e.pr, e.rl, e.rp);
                end
            end else if ((btn_press | btn_release | btn_repeat) !== '0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe edge=%0d got p/r/rp=%b/%b/%b exp=000/000/000",
                         cur_edge, btn_press, btn_release, btn_repeat);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [CH-1:0] rep_exp;
    int            hold[CH];

    initial begin
        rep_exp = REP_ON ? 3'b111 : 3'b000;
        rst     = 1'b0;
        btn_in  = '0;
        step(3);
        chk("reset_level",   32'(btn_level),   0);
        chk("reset_press",   32'(btn_press),   0);
        chk("reset_release", 32'(btn_release), 0);
        chk("reset_repeat",  32'(btn_repeat),  0);
        @(negedge clk) rst = 1'b1;
        step(1);

        // Clean press on ch0
        btn_in[0] = 1'b1;
        step(5); chk("s1_level_before", 32'(btn_level), 0);
        step(1); chk("s1_level", 32'(btn_level), 32'b001);
                 chk("s1_press", 32'(btn_press), 32'b001);
        step(1); chk("s1_press_gone", 32'(btn_press), 0);

        // Bounce on ch1
        for (int r = 0; r < 2; r++) begin
            btn_in[1] = 1'b1; step(3);
            btn_in[1] = 1'b0; step(2);
        end
        btn_in[1] = 1'b1;
        step(5); chk("s2_level_before", 32'(btn_level), 32'b001);
        step(1); chk("s2_press", 32'(btn_press), 32'b010);

        // Release ch0
        btn_in[0] = 1'b0;
        step(5); chk("s3_release_before", 32'(btn_release), 0);
        step(1); chk("s3_release", 32'(btn_release), 32'b001);
                 chk("s3_level", 32'(btn_level), 32'b010);
        step(4);

        // Simultaneous press on ch0 and ch2
        btn_in[0] = 1'b1; btn_in[2] = 1'b1;
        step(6); chk("s4_press", 32'(btn_press), 32'b101);
                 chk("s4_level", 32'(btn_level), 32'b111);
        btn_in[0] = 1'b0;
        step(8); chk("s4_level_after", 32'(btn_level), 32'b110);

        // Reset mid-count on ch0 while ch1/ch2 are held
        btn_in[0] = 1'b1;
        step(4);
        #2 rst = 1'b0;
        #1 chk("s5_async_clear", 32'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step(5); chk("s5_level_before", 32'(btn_level), 0);
        step(1); chk("s5_press", 32'(btn_press), 32'b111);

        // Auto-repeat while held
        step(9);  chk("s6_repeat_p9",  32'(btn_repeat), 0);
        step(1);  chk("s6_repeat_p10", 32'(btn_repeat), 32'(rep_exp));
        step(1);  chk("s6_repeat_p11", 32'(btn_repeat), 0);
        step(2);  chk("s6_repeat_p13", 32'(btn_repeat), 32'(rep_exp));
        step(3);  chk("s6_repeat_p16", 32'(btn_repeat), 32'(rep_exp));
        btn_in = '0;
        step(40); chk("s6_level_released", 32'(btn_level), 0);

        // Random toggling with one mid-run reset
        for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 9);
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    btn_in[c] = ~btn_in[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                          : $urandom_range(1, 9);
                end
            end
            if (i == 700) begin
                #2 rst = 1'b0;
                @(negedge clk) rst = 1'b1;
            end
            step(1);
        end
        btn_in = '0;
        step(20);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
